// File: rtl/cop_ise_pkg.sv
// Shared definitions for the masked custom-0 ISE coprocessor.
//   - funct[2:0] operation codes
//   - FSM state encoding
//   - helpers: timing-randomisation mask and reserved-code decode
package cop_ise_pkg;

    localparam logic [2:0] FnAdd    = 3'b000;
    localparam logic [2:0] FnMul    = 3'b001;
    localparam logic [2:0] FnRdRand = 3'b010;
    localparam logic [2:0] FnSub    = 3'b011;
    localparam logic [2:0] FnXor    = 3'b100;
    localparam logic [2:0] FnRdHigh = 3'b111;

    typedef enum logic [3:0] {
        StIdle,
        StRng,
        StMask,
        StStep1,
        StWait1,
        StStep2,
        StWait2,
        StStep3,
        StWait3,
        StHigh,
        StDone
    } state_e;

    // Delay mask (2^(k+1))-1; callers truncate to their counter width.
    function automatic logic [7:0] dly_mask(input logic [2:0] k);
        return 8'hFF >> (3'd7 - k);
    endfunction

    function automatic logic fn_reserved(input logic [2:0] fn);
        return (fn == 3'b101) || (fn == 3'b110);
    endfunction

endpackage

// File: rtl/cop_ise_tdelay.sv
// Random execution-time padding counter.
// Ports:
//   i_clk   clock (rising edge)
//   i_rst_n synchronous active-low reset, clears the count
//   i_load  load i_val (takes priority over i_dec)
//   i_dec   decrement while non-zero
//   i_val   load value
//   o_zero  count is zero
module cop_ise_tdelay #(
    parameter int unsigned DLY_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [DLY_W-1:0] i_val,
    output logic             o_zero
);

    logic [DLY_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cop_ise_masked.sv
// Masked custom-0 ISE coprocessor: ADD/SUB/XOR/MUL on randomly split shares,
// RDRAND and RDHIGH, with optional random padding between steps.
// Ports:
//   cop_clk, cop_rst_n         clock, synchronous active-low reset
//   cop_valid/insn/rs1/rs2     instruction offer and operands
//   cop_ready, cop_wr          one-cycle completion / writeback pulses
//   cop_rd                     low half of the result register
//   cop_wait                   busy (state != idle)
//   rng_req/rng_ack/rng_data   external random-word handshake
module cop_ise_masked
    import cop_ise_pkg::*;
#(
    parameter logic [6:0]  CUSOPCODE = 7'b0001011,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DLY_W     = 8
) (
    input  logic              cop_clk,
    input  logic              cop_rst_n,
    input  logic              cop_valid,
    input  logic [31:0]       cop_insn,
    input  logic [XLEN-1:0]   cop_rs1,
    input  logic [XLEN-1:0]   cop_rs2,
    output logic              cop_ready,
    output logic              cop_wr,
    output logic [XLEN-1:0]   cop_rd,
    output logic              cop_wait,
    output logic              rng_req,
    input  logic              rng_ack,
    input  logic [2*XLEN-1:0] rng_data
);

    localparam int unsigned W2 = 2 * XLEN;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_a, r_b;
    logic [6:0]      r_funct;
    logic [W2-1:0]   r_res, r_rnd;
    // Shares keep their carry bit so the unmasking steps are exact mod 2^W2.
    logic [XLEN:0]   r_sa, r_sb;

    logic            w_accept;
    logic [2:0]      w_fn;
    logic [W2-1:0]   w_a_x, w_r0_x, w_r1_x, w_sa_x, w_sb_x;
    logic [W2-1:0]   w_mul_a, w_mul_b, w_prod, w_res_step;
    logic [7:0]      w_dly_byte, w_dly_mask;
    logic [DLY_W-1:0] w_dly_val;
    logic            w_dly_load, w_dly_dec, w_dly_zero;
    logic            w_unused_insn;

    assign w_unused_insn = ^cop_insn[24:7];

    assign w_accept = (r_state == StIdle) && cop_valid && (cop_insn[6:0] == CUSOPCODE);
    assign w_fn     = r_funct[2:0];

    assign w_a_x  = {{XLEN{1'b0}}, r_a};
    assign w_r0_x = {{XLEN{1'b0}}, r_rnd[XLEN-1:0]};
    assign w_r1_x = {{XLEN{1'b0}}, r_rnd[W2-1:XLEN]};
    assign w_sa_x = {{(XLEN-1){1'b0}}, r_sa};
    assign w_sb_x = {{(XLEN-1){1'b0}}, r_sb};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge cop_clk) begin
        if (!cop_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    case (cop_insn[27:25])
                        FnAdd, FnMul, FnRdRand, FnSub, FnXor: w_state_nxt = StRng;
                        FnRdHigh:                             w_state_nxt = StHigh;
                        default:                              w_state_nxt = StDone;
                    endcase
                end
            end
            StRng: begin
                if (rng_ack) begin
                    w_state_nxt = (w_fn == FnRdRand) ? StDone : StMask;
                end
            end
            StMask:  w_state_nxt = StStep1;
            StStep1: w_state_nxt = StWait1;
            StWait1: if (w_dly_zero) w_state_nxt = StStep2;
            StStep2: w_state_nxt = StWait2;
            StWait2: if (w_dly_zero) w_state_nxt = (w_fn == FnMul) ? StStep3 : StDone;
            StStep3: w_state_nxt = StWait3;
            StWait3: if (w_dly_zero) w_state_nxt = StDone;
            StHigh:  w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    assign cop_ready = (r_state == StDone);
    assign cop_wr    = (r_state == StDone) && !fn_reserved(w_fn);
    assign cop_wait  = (r_state != StIdle);
    assign rng_req   = (r_state == StRng);
    assign cop_rd    = r_res[XLEN-1:0];

    // ------------------------------------------------------- delay padding
    always_comb begin
        w_dly_byte = r_rnd[7:0];
        case (r_state)
            StStep2: w_dly_byte = r_rnd[15:8];
            StStep3: w_dly_byte = r_rnd[23:16];
            default: ;
        endcase
    end

    assign w_dly_mask = dly_mask(r_funct[5:3]);
    assign w_dly_val  = r_funct[6] ? (w_dly_mask[DLY_W-1:0] & w_dly_byte[DLY_W-1:0]) : '0;
    assign w_dly_load = (r_state == StStep1) || (r_state == StStep2) || (r_state == StStep3);
    assign w_dly_dec  = (r_state == StWait1) || (r_state == StWait2) || (r_state == StWait3);

    cop_ise_tdelay #(
        .DLY_W (DLY_W)
    ) u_tdelay (
        .i_clk   (cop_clk),
        .i_rst_n (cop_rst_n),
        .i_load  (w_dly_load),
        .i_dec   (w_dly_dec),
        .i_val   (w_dly_val),
        .o_zero  (w_dly_zero)
    );

    // ----------------------------------------------------------- datapath
    // Single multiplier; operands selected by the step being executed.
    always_comb begin
        w_mul_a = w_sa_x;
        w_mul_b = w_sb_x;
        if (r_state == StStep2) begin
            w_mul_a = w_r0_x;
        end else if (r_state == StStep3) begin
            w_mul_a = w_a_x;
            w_mul_b = w_r1_x;
        end
    end

    assign w_prod = w_mul_a * w_mul_b;

    always_comb begin
        w_res_step = r_res;
        case (r_state)
            StStep1: begin
                case (w_fn)
                    FnAdd:   w_res_step = w_sa_x + w_sb_x;
                    FnSub:   w_res_step = w_sa_x - w_sb_x;
                    FnXor:   w_res_step = w_sa_x ^ w_sb_x;
                    default: w_res_step = w_prod;
                endcase
            end
            StStep2: begin
                case (w_fn)
                    FnAdd:   w_res_step = r_res - (w_r0_x + w_r1_x);
                    FnSub:   w_res_step = r_res - (w_r0_x - w_r1_x);
                    FnXor:   w_res_step = r_res ^ (w_r0_x ^ w_r1_x);
                    default: w_res_step = r_res - w_prod;
                endcase
            end
            StStep3: w_res_step = r_res - w_prod;
            StHigh:  w_res_step = {r_res[W2-1:XLEN], r_res[W2-1:XLEN]};
            default: ;
        endcase
    end

    always_ff @(posedge cop_clk) begin
        if (!cop_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_funct <= '0;
            r_rnd   <= '0;
            r_res   <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_a     <= cop_rs1;
                        r_b     <= cop_rs2;
                        r_funct <= cop_insn[31:25];
                    end
                end
                StRng: begin
                    if (rng_ack) begin
                        r_rnd <= rng_data;
                        if (w_fn == FnRdRand) begin
                            r_res <= rng_data;
                        end
                    end
                end
                StMask: begin
                    if (w_fn == FnXor) begin
                        r_sa <= {1'b0, r_a ^ r_rnd[XLEN-1:0]};
                        r_sb <= {1'b0, r_b ^ r_rnd[W2-1:XLEN]};
                    end else begin
                        r_sa <= {1'b0, r_a} + {1'b0, r_rnd[XLEN-1:0]};
                        r_sb <= {1'b0, r_b} + {1'b0, r_rnd[W2-1:XLEN]};
                    end
                end
                StStep1, StStep2, StStep3, StHigh: r_res <= w_res_step;
                default: ;
            endcase
        end
    end

endmodule
